fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage and IF/ID pipeline register for the single-issue RV32I core. It holds the PC and issues word requests to instruction memory over a request/grant/response handshake. It registers each returned instruction with its PC and presents `instOut` and `opcodeOut` to the decode stage, which includes the immediate generator. It also handles decode back-pressure (`idStall`) and control-flow redirects (flush plus refetch).

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013 (`addi x0,x0,0`): value driven on `instOut` whenever `validOut`=0.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imemReq` out 1: fetch request.
- `imemAddr` out 32: word address, always 4-byte aligned.
- `imemGnt` in 1: request accepted in any cycle where `imemReq`&&`imemGnt`.
- `imemRvalid` in 1: response strobe. Exactly one per accepted request, arriving at least 1 cycle after grant.
- `imemRdata` in 32: instruction word, valid with `imemRvalid`.
- `redirect` in 1: taken branch/jump from execute.
- `redirectPc` in 32: redirect target.
- `idStall` in 1: decode cannot accept; hold the output register.
- `instOut` out 32: registered instruction.
- `pcOut` out 32: PC of `instOut`.
- `opcodeOut` out 7: always equals `instOut[6:0]`.
- `validOut` out 1: `instOut`/`pcOut` hold a live instruction.
- `misalignOut` out 1: present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- Maximum one outstanding memory request.
- Registers:
  - `pc`
  - `reqPc` (address of the outstanding request)
  - `kill` flag
  - one-entry hold buffer (`holdInst`, `holdPc`)
  - output register
- FSM states are REQ, WAIT and HOLD (plus FAULT, macro only).
- REQ:
  - Drive `imemReq`=1 and `imemAddr`=`pc`.
  - On grant: `reqPc`<=`pc`, `pc`<=`pc`+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to WAIT.
- WAIT:
  - Drive `imemReq`=0.
  - If `imemRvalid` and `kill`=1: discard the data, clear `kill`, go to REQ.
  - Else if `imemRvalid` and the output register is free (`validOut`=0 or `idStall`=0): load `instOut`=`imemRdata`, `pcOut`=`reqPc`, `validOut`=1, go to REQ.
  - Else if `imemRvalid`: capture the word in the hold buffer, go to HOLD.
- HOLD:
  - No requests.
  - When `idStall`=0: move the hold buffer into the output register, go to REQ.
- Output register with no new word and `idStall`=0: `validOut`<=0, `instOut`<=`NOP_INST`, `pcOut` holds its value.
- Output register with `idStall`=1 and `validOut`=1: all outputs hold.
- `redirect` has highest priority and overrides `idStall`:
  - `pc`<=`redirectPc`; `validOut`<=0; `instOut`<=`NOP_INST`; hold buffer dropped.
  - In REQ without grant: stay in REQ. `imemAddr` still shows the old `pc` that cycle and the new target the next cycle.
  - In REQ with grant the same cycle, or in WAIT with no `imemRvalid`: set `kill`, go to (or stay in) WAIT.
  - In WAIT with `imemRvalid` the same cycle: the response is discarded, go to REQ, `kill` stays 0.
  - In HOLD: go to REQ.
- Reset values:
  - `pc`=`RESET_PC`, state REQ, `kill`=0, hold buffer empty.
  - `imemReq`=0 while `rst`=1.
  - `validOut`=0, `instOut`=`NOP_INST`, `opcodeOut`=7'h13, `pcOut`=0, `misalignOut`=0.
- Reset asserted mid-WAIT: the in-flight response still arrives and must be discarded. Reset therefore sets `kill`=1 whenever the state was WAIT.

## Timing
- Grant at cycle N with `imemRvalid` at N+1: `validOut`=1 from cycle N+2.
- Next request is issued at N+2.
- Peak throughput: 1 instruction per 2 cycles.
- Redirect at cycle N: `validOut`=0 from N+1.
- First request to the target no later than N+1, or one cycle after the killed response arrives.
- All outputs are registered except `imemReq` and `imemAddr`, which are decoded from state and `pc`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirectPc[1:0]`≠0 enters FAULT.
  - No requests are issued in FAULT.
  - The output register presents `validOut`=1, `instOut`=`NOP_INST`, `pcOut`=`redirectPc`, `misalignOut`=1, held while `idStall`=1.
  - After it is consumed, `validOut`=0 and the unit stays in FAULT until the next redirect.
- Undefined: the `misalignOut` port is absent and `redirectPc[1:0]` is treated as 2'b00.

## Test plan
- Reset, `imemGnt`=1, memory returns 0x00500093 one cycle after grant → `imemAddr`=0x0 then 0x4; `validOut`=1 with `pcOut`=0x0, `instOut`=0x00500093, `opcodeOut`=7'h13.
- `idStall`=1 for 5 cycles while words for 0x4 and 0x8 are fetched → 0x4 held at the output, 0x8 in the hold buffer, no request for 0xC until `idStall` drops; then 0x8 is presented the next cycle.
- Redirect to 0x100 while WAIT for 0x8, response arriving 3 cycles later → 0x8 data never appears on `instOut`; the next valid output has `pcOut`=0x100.
- Redirect to 0x200 in the same cycle as `imemRvalid` → response dropped, `kill` stays 0, next request address 0x200.
- `pc`=0xFFFF_FFFC granted → next `imemAddr`=0x0000_0000.
- With the macro, redirect to 0x102 → `misalignOut`=1, `pcOut`=0x102, `imemReq` stays 0 until a redirect to 0x104.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register for the RV32I core.
// Optional misaligned-redirect fault handling is enabled by FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic        idStall,
  output logic [31:0] instOut,
  output logic [31:0] pcOut,
  output logic [6:0]  opcodeOut,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalignOut,
`endif
  output logic        validOut
);

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StReq, StWait, StHold, StFault} state_e;
`else
  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  logic        out_free;
  logic        in_flight;
  logic [31:0] redirect_tgt;

  assign out_free     = !valid_q || !idStall;
  assign redirect_tgt = redirectPc & AlignMask;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    in_flight   = 1'b0;

    // Output consumed with nothing new behind it: drain to a bubble, keep pcOut.
    if (!idStall) begin
      valid_d    = 1'b0;
      inst_d     = NOP_INST;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = 1'b0;
`endif
    end

    case (state_q)
      StReq: begin
        if (imemGnt) begin
          req_pc_d  = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = StWait;
          in_flight = 1'b1;
        end
      end
      StWait: begin
        if (!imemRvalid) begin
          in_flight = 1'b1;
        end else if (kill_q) begin
          kill_d  = 1'b0;
          state_d = StReq;
        end else if (out_free) begin
          inst_d   = imemRdata;
          pc_out_d = req_pc_q;
          valid_d  = 1'b1;
          state_d  = StReq;
        end else begin
          hold_inst_d = imemRdata;
          hold_pc_d   = req_pc_q;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (!idStall) begin
          inst_d   = hold_inst_q;
          pc_out_d = hold_pc_q;
          valid_d  = 1'b1;
          state_d  = StReq;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      StFault: begin
        // A request granted before the fault may still be answered here.
        if (imemRvalid) begin
          kill_d = 1'b0;
        end else if (kill_q) begin
          in_flight = 1'b1;
        end
      end
`endif
      default: state_d = StReq;
    endcase

    // Redirect wins over everything, including idStall.
    if (redirect) begin
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      kill_d  = in_flight;
      state_d = in_flight ? StWait : StReq;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = 1'b0;
      if (redirectPc[1:0] != 2'b00) begin
        state_d    = StFault;
        valid_d    = 1'b1;
        pc_out_d   = redirectPc;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC & AlignMask;
      req_pc_q    <= 32'h0;
      // A response still owed to a pre-reset request must be dropped when it lands.
      kill_q      <= ((state_q == StWait) || kill_q) && !imemRvalid;
      hold_inst_q <= 32'h0;
      hold_pc_q   <= 32'h0;
      inst_q      <= NOP_INST;
      pc_out_q    <= 32'h0;
      valid_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign imemReq   = (state_q == StReq) && !rst;
  assign imemAddr  = pc_q & AlignMask;
  assign instOut   = inst_q;
  assign pcOut     = pc_out_q;
  assign opcodeOut = inst_q[6:0];
  assign validOut  = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalignOut = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus scoreboarded redirect sequences.
// The misaligned-redirect sequence runs only when FETCH_MISALIGN_CHECK_EN is defined.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        idStall = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic [6:0]  opcodeOut;
  logic        validOut;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalignOut;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 1;
  bit sb_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  logic [31:0] sb_w;

  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemGnt    (imemGnt),
    .imemRvalid (imemRvalid),
    .imemRdata  (imemRdata),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .idStall    (idStall),
    .instOut    (instOut),
    .pcOut      (pcOut),
    .opcodeOut  (opcodeOut),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalignOut(misalignOut),
`endif
    .validOut   (validOut)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[24:0], a[8:2]};
  endfunction

  // Instruction memory: one response per grant, lat cycles after the grant.
  always @(posedge clk) begin
    imemRvalid <= 1'b0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imemRvalid <= 1'b1;
        imemRdata  <= memword(mem_addr);
        mem_pend   <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
    if (imemReq && imemGnt) begin
      if (lat <= 1) begin
        imemRvalid <= 1'b1;
        imemRdata  <= memword(imemAddr);
      end else begin
        mem_pend <= 1'b1;
        mem_cnt  <= lat - 1;
        mem_addr <= imemAddr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every instruction decode accepts must be the next expected PC.
  always @(negedge clk) begin
    if (sb_en && validOut && !idStall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got pcOut %h, expected no instruction", pcOut);
      end else begin
        sb_e = exp_q.pop_front();
        sb_w = memword(sb_e);
        chk("sb_pc", pcOut, sb_e);
        chk("sb_inst", instOut, sb_w);
        chk("sb_opcode", 32'(opcodeOut), 32'(sb_w[6:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr, input int max_cyc);
    bit found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      tick();
      if (imemReq && imemAddr == addr) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_req: got no request for %h within %0d cycles, expected one", addr,
               max_cyc);
    end
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;
  endtask

  task automatic reset_dut();
    imemGnt  = 1'b0;
    redirect = 1'b0;
    idStall  = 1'b0;
    sb_en    = 1'b0;
    for (int i = 0; i < 20 && (mem_pend || imemRvalid); i++) tick();
    chk("mem_idle", 32'(mem_pend || imemRvalid), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_inst;

    // Grant always, one-cycle memory; decode stalls for five cycles mid-stream.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h8};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h8};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC};

    lat     = 1;
    imemGnt = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 14; i++) begin
      rst     = tbl[i].rst;
      idStall = tbl[i].stall;
      #1;
      exp_inst = tbl[i].valid ? memword(tbl[i].pc) : Nop;
      chk($sformatf("row%0d_req", i), 32'(imemReq), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("row%0d_addr", i), imemAddr, tbl[i].addr);
      chk($sformatf("row%0d_valid", i), 32'(validOut), 32'(tbl[i].valid));
      chk($sformatf("row%0d_pc", i), pcOut, tbl[i].pc);
      chk($sformatf("row%0d_inst", i), instOut, exp_inst);
      chk($sformatf("row%0d_opcode", i), 32'(opcodeOut), 32'(exp_inst[6:0]));
      tick();
    end

    // Redirect while waiting on a slow response for 0x8: that word must never surface.
    reset_dut();
    lat     = 3;
    imemGnt = 1'b1;
    sb_en   = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    wait_req(32'h8, 40);
    tick();
    redirect   = 1'b1;
    redirectPc = 32'h100;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    tick();
    redirect = 1'b0;
    chk("redir_wait_valid", 32'(validOut), 32'd0);
    chk("redir_wait_inst", instOut, Nop);
    wait_req(32'h100, 20);
    drain(80);

    // Redirect in the same cycle as the response: no kill, target fetched next cycle.
    reset_dut();
    lat     = 1;
    imemGnt = 1'b1;
    sb_en   = 1'b1;
    tick();
    redirect   = 1'b1;
    redirectPc = 32'h200;
    exp_q.push_back(32'h200);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_rv_req", 32'(imemReq), 32'd1);
    chk("redir_rv_addr", imemAddr, 32'h200);
    chk("redir_rv_valid", 32'(validOut), 32'd0);
    drain(20);

    // Redirect on a granted request to the top word, then the PC wraps to zero.
    reset_dut();
    lat        = 1;
    imemGnt    = 1'b1;
    sb_en      = 1'b1;
    redirect   = 1'b1;
    redirectPc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    redirect = 1'b0;
    chk("wrap_valid", 32'(validOut), 32'd0);
    wait_req(32'hFFFF_FFFC, 10);
    wait_req(32'h0, 10);
    drain(30);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned target: fault presented, no fetches until an aligned redirect.
    reset_dut();
    lat        = 1;
    imemGnt    = 1'b1;
    redirect   = 1'b1;
    redirectPc = 32'h102;
    tick();
    redirect = 1'b0;
    idStall  = 1'b1;
    #1;
    chk("mis_flag", 32'(misalignOut), 32'd1);
    chk("mis_valid", 32'(validOut), 32'd1);
    chk("mis_pc", pcOut, 32'h102);
    chk("mis_inst", instOut, Nop);
    chk("mis_req", 32'(imemReq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_hold_flag", 32'(misalignOut), 32'd1);
      chk("mis_hold_valid", 32'(validOut), 32'd1);
      chk("mis_hold_req", 32'(imemReq), 32'd0);
    end
    idStall = 1'b0;
    tick();
    chk("mis_done_valid", 32'(validOut), 32'd0);
    chk("mis_done_flag", 32'(misalignOut), 32'd0);
    tick();
    chk("mis_idle_req", 32'(imemReq), 32'd0);
    redirect   = 1'b1;
    redirectPc = 32'h104;
    tick();
    redirect = 1'b0;
    #1;
    chk("mis_exit_req", 32'(imemReq), 32'd1);
    chk("mis_exit_addr", imemAddr, 32'h104);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
